// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - ID-stage branch type encodings (id_br_type)
//   - the architectural zero register, which never creates a dependence
//   - controller FSM state encoding
package hazard_pkg;

  localparam logic [1:0] BR_BEZ  = 2'b00;  // compares src1 only
  localparam logic [1:0] BR_BNE  = 2'b01;  // compares src1 and src2
  localparam logic [1:0] BR_JMP  = 2'b10;  // reads no registers
  localparam logic [1:0] BR_NONE = 2'b11;  // not a branch

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_compare.sv
// Combinational source/destination match for one later pipeline stage.
// Ports:
//   src1, src2     ID-stage source register numbers
//   use_src1/2     the ID instruction actually reads that source
//   dest           destination register of the stage being compared
//   wb_en          that stage will write its destination back
//   match          ID depends on the stage's pending write
module hazard_compare
  import hazard_pkg::*;
(
  input  logic [4:0] src1,
  input  logic [4:0] src2,
  input  logic       use_src1,
  input  logic       use_src2,
  input  logic [4:0] dest,
  input  logic       wb_en,
  output logic       match
);

  logic hit1;
  logic hit2;

  // Register zero is hardwired, so a write to it never produces a dependence.
  assign hit1  = use_src1 && (src1 != REG_ZERO) && (src1 == dest);
  assign hit2  = use_src2 && (src2 != REG_ZERO) && (src2 == dest);
  assign match = wb_en && (hit1 || hit2);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Front-of-pipe sequencer for a 5-stage pipeline.
// Detects RAW hazards between the ID sources and the EXE/MEM destinations,
// flushes IF/ID on a taken branch and freezes the whole pipe while the data
// memory is busy, with a watchdog that aborts an over-long memory wait.
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   src1, src2          ID source registers; one_input masks src2
//   id_br_type          ID branch type (selects which sources are read)
//   exe_*/mem_*         destination, write-back enable and load flag of EXE/MEM
//   branch_taken        EXE resolved a taken branch this cycle
//   mem_req, mem_ready  data memory access in MEM and its completion
//   stat_clr            synchronous clear of counters and mem_timeout
//   hazard_detection    bubble into ID
//   freeze_if           hold PC and IF/ID
//   flush_if_id         clear IF/ID
//   freeze_pipe         hold every pipeline register (memory wait)
//   mem_timeout         sticky watchdog flag
//   stall_cycles        saturating count of freeze_if|freeze_pipe cycles
//   flush_count         saturating count of taken-branch flushes
//   state_dbg           current FSM state
// Handshake: a memory access completes in the cycle mem_ready is high; while
// mem_req is high and mem_ready low the pipe is frozen in that same cycle.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter bit          FORWARD_EN  = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       src1,
  input  logic [4:0]       src2,
  input  logic             one_input,
  input  logic [1:0]       id_br_type,
  input  logic [4:0]       exe_dest,
  input  logic [4:0]       mem_dest,
  input  logic             exe_wb_en,
  input  logic             mem_wb_en,
  input  logic             exe_mem_r_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             stat_clr,
  output logic             hazard_detection,
  output logic             freeze_if,
  output logic             flush_if_id,
  output logic             freeze_pipe,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output state_e           state_dbg
);

  localparam int unsigned    WCW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  // ---------------------------------------------------------------- hazards
  logic use_src1;
  logic use_src2;
  logic exe_match;
  logic mem_match;
  logic data_haz;

  assign use_src1 = (id_br_type != BR_JMP);
  assign use_src2 = !one_input && (id_br_type != BR_BEZ) && (id_br_type != BR_JMP);

  hazard_compare u_cmp_exe (
    .src1     (src1),
    .src2     (src2),
    .use_src1 (use_src1),
    .use_src2 (use_src2),
    .dest     (exe_dest),
    .wb_en    (exe_wb_en),
    .match    (exe_match)
  );

  hazard_compare u_cmp_mem (
    .src1     (src1),
    .src2     (src2),
    .use_src1 (use_src1),
    .use_src2 (use_src2),
    .dest     (mem_dest),
    .wb_en    (mem_wb_en),
    .match    (mem_match)
  );

  // With forwarding only a load in EXE cannot be bypassed in time.
  generate
    if (FORWARD_EN) begin : g_fwd
      assign data_haz = exe_match && exe_mem_r_en;
    end else begin : g_nofwd
      assign data_haz = exe_match || mem_match;
    end
  endgenerate

  // ---------------------------------------------------------------- FSM
  state_e           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q;
  logic [CNT_W-1:0] stall_q, flush_q;

  logic hz_c, fif_c, flush_c, fp_c;
  logic timeout_set;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    hz_c        = 1'b0;
    fif_c       = 1'b0;
    flush_c     = 1'b0;
    fp_c        = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          fp_c       = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WCW'(1);
        end else if (branch_taken) begin
          // The flushed instruction in ID is discarded, so its hazard is moot.
          flush_c = 1'b1;
          hz_c    = 1'b1;
        end else if (data_haz) begin
          hz_c  = 1'b1;
          fif_c = 1'b1;
        end
      end
      MEM_WAIT: begin
        // branch_taken is held in EXE by the freeze and is acted on later.
        fp_c = 1'b1;
        if (mem_ready) begin
          fp_c       = 1'b0;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          fp_c        = 1'b0;
          timeout_set = 1'b1;
          state_d     = RUN;
          wait_cnt_d  = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_q       <= '0;
      flush_q       <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (stat_clr) begin
        mem_timeout_q <= 1'b0;
        stall_q       <= '0;
        flush_q       <= '0;
      end else begin
        if (timeout_set) mem_timeout_q <= 1'b1;
        if ((fif_c || fp_c) && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
        if (flush_c && (flush_q != '1))         flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  // Gated by rst so controls drop the instant reset is asserted.
  assign hazard_detection = rst && hz_c;
  assign freeze_if        = rst && fif_c;
  assign flush_if_id      = rst && flush_c;
  assign freeze_pipe      = rst && fp_c;
  assign mem_timeout      = mem_timeout_q;
  assign stall_cycles     = stall_q;
  assign flush_count      = flush_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller. Two instances share all
// inputs: "a" has forwarding (FORWARD_EN=1, 32-bit counters), "b" has none
// (FORWARD_EN=0, 4-bit counters so saturation is reachable). Both use
// MEM_TIMEOUT=8. Inputs change on the falling edge; outputs are sampled 1 ns
// later, well away from the rising edge.
module tb_pipeline_hazard_controller;
  import hazard_pkg::*;

  // ------------------------------------------------------------ clock/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------ DUT signals
  logic [4:0] src1, src2, exe_dest, mem_dest;
  logic       one_input, exe_wb_en, mem_wb_en, exe_mem_r_en;
  logic [1:0] id_br_type;
  logic       branch_taken, mem_req, mem_ready, stat_clr;

  logic        a_hz, a_fif, a_fl, a_fp, a_to;
  logic [31:0] a_stall, a_flcnt;
  state_e      a_state;
  logic        b_hz, b_fif, b_fl, b_fp, b_to;
  logic [3:0]  b_stall, b_flcnt;
  state_e      b_state;

  pipeline_hazard_controller #(.FORWARD_EN(1'b1), .MEM_TIMEOUT(8), .CNT_W(32)) u_a (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .one_input(one_input),
    .id_br_type(id_br_type), .exe_dest(exe_dest), .mem_dest(mem_dest),
    .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .stat_clr(stat_clr), .hazard_detection(a_hz), .freeze_if(a_fif),
    .flush_if_id(a_fl), .freeze_pipe(a_fp), .mem_timeout(a_to),
    .stall_cycles(a_stall), .flush_count(a_flcnt), .state_dbg(a_state)
  );

  pipeline_hazard_controller #(.FORWARD_EN(1'b0), .MEM_TIMEOUT(8), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .one_input(one_input),
    .id_br_type(id_br_type), .exe_dest(exe_dest), .mem_dest(mem_dest),
    .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .stat_clr(stat_clr), .hazard_detection(b_hz), .freeze_if(b_fif),
    .flush_if_id(b_fl), .freeze_pipe(b_fp), .mem_timeout(b_to),
    .stall_cycles(b_stall), .flush_count(b_flcnt), .state_dbg(b_state)
  );

  // ------------------------------------------------------------ scoreboard
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------------ drivers
  task automatic idle();
    src1 = 5'd0; src2 = 5'd0; one_input = 1'b0; id_br_type = BR_NONE;
    exe_dest = 5'd0; mem_dest = 5'd0; exe_wb_en = 1'b0; mem_wb_en = 1'b0;
    exe_mem_r_en = 1'b0; branch_taken = 1'b0; mem_req = 1'b0;
    mem_ready = 1'b0; stat_clr = 1'b0;
  endtask

  task automatic load_use_r5();
    src1 = 5'd5; exe_dest = 5'd5; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
  endtask

  task automatic next_cyc();
    @(negedge clk);
    idle();
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    // Reset: hazard inputs active, yet every control must read 0.
    idle(); load_use_r5();
    #2;
    check("rst_hz_a", a_hz, 1'b0);
    check("rst_hz_b", b_hz, 1'b0);
    check("rst_fif_a", a_fif, 1'b0);
    check("rst_state_a", a_state, RUN);
    check("rst_stall_a", a_stall, 0);
    check("rst_flcnt_b", b_flcnt, 0);
    check("rst_to_a", a_to, 1'b0);
    next_cyc(); rst = 1'b1;

    // Load-use on r5.
    next_cyc(); load_use_r5(); one_input = 1'b1; #1;
    check("lu_hz_a", a_hz, 1'b1);
    check("lu_fif_a", a_fif, 1'b1);
    check("lu_fl_a", a_fl, 1'b0);
    check("lu_fp_a", a_fp, 1'b0);
    check("lu_hz_b", b_hz, 1'b1);
    next_cyc(); #1;
    check("lu_stall_a", a_stall, 1);
    check("lu_after_hz_a", a_hz, 1'b0);
    check("lu_stall_b", b_stall, 1);

    // No false hazards: register zero, and src2 masked by one_input.
    src1 = 5'd0; exe_dest = 5'd0; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; #1;
    check("r0_hz_a", a_hz, 1'b0);
    check("r0_hz_b", b_hz, 1'b0);
    next_cyc(); one_input = 1'b1; src1 = 5'd1; src2 = 5'd7; exe_dest = 5'd7;
    exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; mem_dest = 5'd7; mem_wb_en = 1'b1; #1;
    check("onein_hz_a", a_hz, 1'b0);
    check("onein_fif_b", b_fif, 1'b0);

    // No forwarding: MEM-stage dependence through src2 of BNE.
    next_cyc(); id_br_type = BR_BNE; src1 = 5'd1; src2 = 5'd3;
    mem_dest = 5'd3; mem_wb_en = 1'b1; #1;
    check("bne_hz_b", b_hz, 1'b1);
    check("bne_fif_b", b_fif, 1'b1);
    check("bne_hz_a", a_hz, 1'b0);
    next_cyc(); id_br_type = BR_JMP; src1 = 5'd3; src2 = 5'd3;
    mem_dest = 5'd3; mem_wb_en = 1'b1; #1;
    check("jmp_hz_b", b_hz, 1'b0);
    next_cyc(); id_br_type = BR_BEZ; src1 = 5'd1; src2 = 5'd3;
    mem_dest = 5'd3; mem_wb_en = 1'b1; #1;
    check("bez_src2_hz_b", b_hz, 1'b0);
    next_cyc(); src1 = 5'd4; exe_dest = 5'd4; exe_wb_en = 1'b1; #1;
    check("alu_hz_a", a_hz, 1'b0);
    check("alu_hz_b", b_hz, 1'b1);
    next_cyc(); #1;
    check("fwd0_stall_b", b_stall, 3);
    check("fwd0_stall_a", a_stall, 1);

    // Taken branch together with a load-use hazard.
    load_use_r5(); branch_taken = 1'b1; #1;
    check("br_fl_a", a_fl, 1'b1);
    check("br_hz_a", a_hz, 1'b1);
    check("br_fif_a", a_fif, 1'b0);
    check("br_fl_b", b_fl, 1'b1);
    check("br_fif_b", b_fif, 1'b0);
    next_cyc(); #1;
    check("br_flcnt_a", a_flcnt, 1);
    check("br_flcnt_b", b_flcnt, 1);
    check("br_stall_a", a_stall, 1);

    // Access completing in the same cycle: no stall.
    mem_req = 1'b1; mem_ready = 1'b1; #1;
    check("memrdy_fp_a", a_fp, 1'b0);
    next_cyc(); #1;
    check("memrdy_state_a", a_state, RUN);

    // Memory wait: not ready in the request cycle plus 4 wait cycles.
    mem_req = 1'b1; #1;
    check("mw_first_fp_a", a_fp, 1'b1);
    check("mw_first_state_a", a_state, RUN);
    for (int k = 0; k < 4; k++) begin
      next_cyc(); mem_req = 1'b1; branch_taken = (k == 1); load_use_r5(); #1;
      check("mw_fp_a", a_fp, 1'b1);
      check("mw_fl_a", a_fl, 1'b0);
      check("mw_hz_a", a_hz, 1'b0);
      check("mw_fif_a", a_fif, 1'b0);
      check("mw_state_a", a_state, MEM_WAIT);
    end
    next_cyc(); mem_ready = 1'b1; #1;
    check("mw_rdy_fp_a", a_fp, 1'b0);
    check("mw_rdy_fp_b", b_fp, 1'b0);
    next_cyc(); #1;
    check("mw_exit_state_a", a_state, RUN);
    check("mw_exit_fp_a", a_fp, 1'b0);
    check("mw_flcnt_a", a_flcnt, 1);
    check("mw_stall_a", a_stall, 6);
    check("mw_stall_b", b_stall, 8);

    // Watchdog: ready stuck low; 7 frozen cycles then the abort cycle.
    for (int k = 0; k < 8; k++) begin
      if (k > 0) next_cyc();
      mem_req = 1'b1; #1;
      check("wd_fp_a", a_fp, (k < 7));
      check("wd_to_pre_a", a_to, 1'b0);
    end
    next_cyc(); #1;
    check("wd_to_a", a_to, 1'b1);
    check("wd_to_b", b_to, 1'b1);
    check("wd_state_a", a_state, RUN);
    check("wd_fp_after_a", a_fp, 1'b0);
    check("wd_stall_a", a_stall, 13);
    check("wd_stall_b", b_stall, 15);

    // Counter saturation on the 4-bit instance.
    load_use_r5(); #1;
    check("sat_fif_a", a_fif, 1'b1);
    next_cyc(); #1;
    check("sat_stall_a", a_stall, 14);
    check("sat_stall_b", b_stall, 15);
    check("sat_to_sticky_a", a_to, 1'b1);

    // stat_clr beats a same-cycle increment and clears the watchdog flag.
    load_use_r5(); stat_clr = 1'b1; #1;
    next_cyc(); #1;
    check("clr_stall_a", a_stall, 0);
    check("clr_flcnt_a", a_flcnt, 0);
    check("clr_to_a", a_to, 1'b0);
    check("clr_stall_b", b_stall, 0);
    check("clr_to_b", b_to, 1'b0);

    // Asynchronous reset in the middle of a memory wait.
    mem_req = 1'b1; #1;
    next_cyc(); mem_req = 1'b1; #1;
    check("arst_pre_fp_a", a_fp, 1'b1);
    check("arst_pre_state_a", a_state, MEM_WAIT);
    rst = 1'b0; #1;
    check("arst_fp_a", a_fp, 1'b0);
    check("arst_fp_b", b_fp, 1'b0);
    check("arst_state_a", a_state, RUN);
    next_cyc(); rst = 1'b1; #1;
    check("arst_after_fp_a", a_fp, 1'b0);
    check("arst_after_state_a", a_state, RUN);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
